adder_pipe_arbiter: RTL and testbench

Shares one pipelined wide adder (Adder_pipe instance, fixed SUB mode) among NUM_REQ requesters. Round-robin grants one operand pair per cycle, registers it into the adder, and tracks requester ids in a tag pipeline matched to the adder latency. Each result is returned to its owner; per-requester outstanding limits and an alignment check guard the pipeline. Sits between compute clients and the shared Adder_pipe in the arithmetic subsystem.

---
 rtl/adder_pipe_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_adder_pipe_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_arbiter.sv
// Round-robin front end for one shared pipelined adder (SUB mode is fixed inside the adder).
// Grants at most one requester per cycle, registers its operand pair into the adder, and
// carries the requester id through a tag pipeline as deep as the adder latency. Each result
// is then registered and returned to the requester that owns it.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_a/b/cin         per-requester operands, requester i at slice i
//   add_*               interface to the shared adder
//   rsp_valid           one-hot result strobe, no backpressure
//   rsp_s/rsp_cout      shared result bus
//   busy                any operation in flight
//   err_misalign        sticky: tag pipeline and adder out_valid disagreed
module adder_pipe_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned IN_WIDTH        = 2048,
  parameter int unsigned LATENCY         = 22,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*IN_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ-1:0]           req_cin,
  output logic                         add_in_valid,
  output logic [IN_WIDTH-1:0]          add_a,
  output logic [IN_WIDTH-1:0]          add_b,
  output logic                         add_cin,
  input  logic [IN_WIDTH-1:0]          add_s,
  input  logic                         add_cout,
  input  logic                         add_out_valid,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [IN_WIDTH-1:0]          rsp_s,
  output logic                         rsp_cout,
  output logic                         busy,
  output logic                         err_misalign
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);
  localparam logic [IdW-1:0]  LastId = IdW'(NUM_REQ - 1);

  logic [IdW-1:0]      rr_q, rr_d;
  logic [CntW-1:0]     cnt_q [NUM_REQ];
  logic [CntW-1:0]     cnt_d [NUM_REQ];
  logic                add_in_valid_q;
  logic [IN_WIDTH-1:0] add_a_q, add_b_q;
  logic                add_cin_q;
  logic [IdW-1:0]      id_q;
  logic [LATENCY-1:0]  tag_vld_q;
  logic [IdW-1:0]      tag_id_q [LATENCY];
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [IN_WIDTH-1:0] rsp_s_q;
  logic                rsp_cout_q;
  logic                err_q;

  logic [NUM_REQ-1:0]  eligible;
  logic                grant_vld;
  logic [IdW-1:0]      grant_id;
  logic [IdW-1:0]      cand;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                head_vld;
  logic [IdW-1:0]      head_id;
  logic                rsp_fire;
  logic                cnt_any;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < MaxCnt);
    end
  end

  // Scan upward from the rr pointer with wrap; first eligible requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = rr_q;
    cand      = rr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdW'((32'(rr_q) + k) % NUM_REQ);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign grant_oh  = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
  assign req_ready = reset ? '0 : grant_oh;

  always_comb begin
    rr_d = rr_q;
    if (grant_vld) begin
      rr_d = (grant_id == LastId) ? '0 : grant_id + 1'b1;
    end
  end

  assign head_vld = tag_vld_q[LATENCY-1];
  assign head_id  = tag_id_q[LATENCY-1];
  assign rsp_fire = head_vld && add_out_valid;

  // A head tag frees its slot even when the adder failed to produce a result for it.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((grant_vld && grant_id == IdW'(i)) &&
          !(head_vld && head_id == IdW'(i) && cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!(grant_vld && grant_id == IdW'(i)) &&
                   (head_vld && head_id == IdW'(i) && cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    cnt_any = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_any = cnt_any | (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q           <= '0;
      add_in_valid_q <= 1'b0;
      add_a_q        <= '0;
      add_b_q        <= '0;
      add_cin_q      <= 1'b0;
      id_q           <= '0;
      tag_vld_q      <= '0;
      rsp_valid_q    <= '0;
      rsp_s_q        <= '0;
      rsp_cout_q     <= 1'b0;
      err_q          <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      rr_q           <= rr_d;
      add_in_valid_q <= grant_vld;
      if (grant_vld) begin
        add_a_q   <= req_a[32'(grant_id) * IN_WIDTH +: IN_WIDTH];
        add_b_q   <= req_b[32'(grant_id) * IN_WIDTH +: IN_WIDTH];
        add_cin_q <= req_cin[grant_id];
        id_q      <= grant_id;
      end
      // Tag enters while add_in_valid is high so its head lines up with add_out_valid.
      tag_vld_q[0] <= add_in_valid_q;
      tag_id_q[0]  <= id_q;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      rsp_valid_q <= rsp_fire ? (NUM_REQ'(1) << head_id) : '0;
      if (rsp_fire) begin
        rsp_s_q    <= add_s;
        rsp_cout_q <= add_cout;
      end
      if (head_vld != add_out_valid) begin
        err_q <= 1'b1;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign add_in_valid = add_in_valid_q;
  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign add_cin      = add_cin_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_s        = rsp_s_q;
  assign rsp_cout     = rsp_cout_q;
  assign busy         = cnt_any || add_in_valid_q || (|tag_vld_q);
  assign err_misalign = err_q;

endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// Bench for adder_pipe_arbiter: a behavioural SUB-mode adder stub closes the loop, and a
// transaction-level model (rr pointer, per-requester counts, queue of expected responses
// stamped with their due cycle) is compared against the DUT on every falling edge.
module tb_adder_pipe_arbiter;
  localparam int N    = 4;
  localparam int W    = 2048;
  localparam int LAT  = 22;
  localparam int MAXO = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     req_cin = '0;
  logic             add_in_valid;
  logic [W-1:0]     add_a, add_b, add_s;
  logic             add_cin, add_cout, add_out_valid;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_s;
  logic             rsp_cout, busy, err_misalign;
  logic             force_ov = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_pipe_arbiter #(
    .NUM_REQ(N), .IN_WIDTH(W), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_in_valid(add_in_valid), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_out_valid(add_out_valid),
    .rsp_valid(rsp_valid), .rsp_s(rsp_s), .rsp_cout(rsp_cout),
    .busy(busy), .err_misalign(err_misalign)
  );

  // SUB-mode adder: {cout, s} = a + ~b + cin.
  function automatic logic [W:0] sub_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
  endfunction

  // Adder stub, LAT cycles from in_valid to out_valid, reset from the same source.
  logic [W:0]     st_s [LAT];
  logic [LAT-1:0] st_v;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      st_v <= '0;
      for (int i = 0; i < LAT; i++) st_s[i] <= '0;
    end else begin
      st_v     <= {st_v[LAT-2:0], add_in_valid};
      st_s[0]  <= sub_ref(add_a, add_b, add_cin);
      for (int i = 1; i < LAT; i++) st_s[i] <= st_s[i-1];
    end
  end
  assign add_s         = st_s[LAT-1][W-1:0];
  assign add_cout      = st_s[LAT-1][W];
  assign add_out_valid = st_v[LAT-1] | force_ov;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_wide(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got low64 %0h expected low64 %0h at t=%0t", name, act[63:0],
               exp[63:0], $time);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  typedef struct {
    int           cyc;
    int           id;
    logic [W-1:0] s;
    logic         cout;
  } rsp_t;

  rsp_t exp_q[$];
  int   m_rr;
  int   m_cnt [N];
  bit   m_err;
  int   cyc = 0;

  always @(negedge clk) begin
    int           win;
    int           tot;
    bit           head_now;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    logic [W:0]   r;
    rsp_t         e;
    if (reset) begin
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_req_ready", 64'(req_ready), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_err", 64'(err_misalign), 64'(0));
      exp_q.delete();
      m_rr  = 0;
      m_err = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (win < 0 && req_valid[idx] && m_cnt[idx] < MAXO) win = idx;
      end
      exp_ready = (win >= 0) ? N'(1 << win) : '0;
      chk("arb_ready", 64'(req_ready), 64'(exp_ready));

      exp_rv = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_rv = N'(1 << exp_q[0].id);
        chk_wide("rsp_s", rsp_s, exp_q[0].s);
        chk("rsp_cout", 64'(rsp_cout), 64'(exp_q[0].cout));
        void'(exp_q.pop_front());
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));

      tot = 0;
      for (int i = 0; i < N; i++) tot += m_cnt[i];
      chk("busy", 64'(busy), 64'(tot != 0));
      chk("err_misalign", 64'(err_misalign), 64'(m_err));

      // Advance the model across the coming rising edge.
      head_now = exp_q.size() > 0 && exp_q[0].cyc == cyc + 1;
      if (add_out_valid != head_now) m_err = 1;
      if (head_now) m_cnt[exp_q[0].id]--;
      if (win >= 0) begin
        r      = sub_ref(req_a[win*W +: W], req_b[win*W +: W], req_cin[win]);
        e.cyc  = cyc + LAT + 2;
        e.id   = win;
        e.s    = r[W-1:0];
        e.cout = r[W];
        exp_q.push_back(e);
        m_cnt[win]++;
        m_rr = (win + 1) % N;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic cin);
    req_a[i*W +: W] = {{(W-64){1'b0}}, a};
    req_b[i*W +: W] = {{(W-64){1'b0}}, b};
    req_cin[i]      = cin;
  endtask

  task automatic set_rand(input int i);
    for (int k = 0; k < W / 32; k++) begin
      req_a[i*W + k*32 +: 32] = $urandom;
      req_b[i*W + k*32 +: 32] = $urandom;
    end
    req_cin[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  logic [N-1:0] rdy_hist [8];
  logic         r0_hist [26];
  logic [N-1:0] rdy;
  int           issued, nrsp, run, maxrun, n0;

  initial begin
    step();
    do_reset();

    // Single op from requester 2: 5 + ~3 + 0 = 1 with carry out.
    set_op(2, 64'd5, 64'd3, 1'b0);
    req_valid = 4'b0100;
    #1 chk("single_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    repeat (23) step();
    #1;
    chk("single_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("single_rsp_s", rsp_s[63:0], 64'd1);
    chk("single_rsp_cout", 64'(rsp_cout), 64'd1);
    step();

    // Round robin from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 64'(100 * (i + 1)), 64'(7 * i), 1'(i % 2));
    req_valid = '1;
    for (int j = 0; j < 8; j++) begin
      #1 rdy_hist[j] = req_ready;
      step();
    end
    req_valid = '0;
    for (int j = 0; j < 8; j++) chk("rr_order", 64'(rdy_hist[j]), 64'(1 << (j % 4)));
    repeat (30) step();

    // Outstanding limit: requester 0 alone.
    set_op(0, 64'hdead_beef, 64'h1234, 1'b1);
    req_valid = 4'b0001;
    for (int j = 0; j < 26; j++) begin
      #1 r0_hist[j] = req_ready[0];
      step();
    end
    n0 = 0;
    for (int j = 0; j < 24; j++) n0 += int'(r0_hist[j]);
    chk("limit_grants_before_rsp", 64'(n0), 64'(MAXO));
    chk("limit_last_grant", 64'(r0_hist[MAXO-1]), 64'd1);
    chk("limit_blocked", 64'(r0_hist[MAXO]), 64'd0);
    chk("limit_regrant_on_rsp", 64'(r0_hist[24]), 64'd1);
    set_op(1, 64'h55, 64'h66, 1'b0);
    req_valid = 4'b0011;
    repeat (40) step();
    req_valid = '0;
    repeat (30) step();

    // Full throughput: 60 back-to-back random ops.
    for (int i = 0; i < N; i++) set_rand(i);
    req_valid = '1;
    issued = 0; nrsp = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 200 && nrsp < 60; c++) begin
      #1;
      rdy = req_ready;
      if (rsp_valid != '0) begin
        nrsp++;
        run++;
        if (run > maxrun) maxrun = run;
        if (nrsp == 60) chk("tp_busy_after_last", 64'(busy), 64'd0);
      end else begin
        run = 0;
      end
      if (rdy != '0) issued++;
      step();
      if (rdy != '0) begin
        if (issued == 60) req_valid = '0;
        else for (int i = 0; i < N; i++) if (rdy[i]) set_rand(i);
      end
    end
    chk("tp_issued", 64'(issued), 64'd60);
    chk("tp_responses", 64'(nrsp), 64'd60);
    chk("tp_consecutive", 64'(maxrun), 64'd60);
    step();

    // Misalignment: spurious out_valid with empty tag pipeline.
    force_ov = 1'b1;
    step();
    force_ov = 1'b0;
    #1 chk("misalign_set", 64'(err_misalign), 64'd1);
    repeat (5) step();
    #1 chk("misalign_sticky", 64'(err_misalign), 64'd1);
    step();

    // Reset with 10 ops in flight.
    for (int i = 0; i < N; i++) set_rand(i);
    req_valid = '1;
    repeat (10) step();
    req_valid = '0;
    repeat (3) step();
    reset     = 1'b1;
    req_valid = '1;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_add_in_valid", 64'(add_in_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err_misalign), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_rsp_s", rsp_s[63:0], 64'd0);
    step();
    step();
    req_valid = '0;
    reset     = 1'b0;
    repeat (30) step();

    // Fresh request after reset: 10 + ~4 + 1 = 6 with carry out.
    set_op(1, 64'd10, 64'd4, 1'b1);
    req_valid = 4'b0010;
    #1 chk("post_rst_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    repeat (23) step();
    #1;
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("post_rst_rsp_s", rsp_s[63:0], 64'd6);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

endmodule
